// File: rtl/cmd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_tx
// Description : SCI command-link frame transmitter. Turns single-cycle
//               RECORD/DAQ request strobes into a 4-byte frame
//               (HEADER0, HEADER1, code, checksum). The frame is sent to the
//               UART transmitter one byte at a time over a valid/ready
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_tx #(
    parameter logic [7:0] HEADER0 = 8'hEB,
    parameter logic [7:0] HEADER1 = 8'h90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_record,
    input  logic       req_daq,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       drop
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_H0   = 3'd1,
        S_H1   = 3'd2,
        S_CODE = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] code_q;
    logic [7:0] code_d;

    // Output registers. Their next values are decoded from the next state,
    // so each output is correct in the same cycle the state changes.
    logic       tx_valid_q;
    logic       tx_valid_d;
    logic [7:0] tx_data_q;
    logic [7:0] tx_data_d;
    logic       busy_q;
    logic       busy_d;
    logic       frame_done_q;
    logic       frame_done_d;
    logic       drop_q;
    logic       drop_d;

    logic       w_any_req;
    logic       w_handshake;

    assign w_any_req   = req_record | req_daq;
    // tx_valid_q is high exactly in the non-IDLE states, so a byte only
    // counts as accepted while a frame is in flight (tx_ready in IDLE is ignored).
    assign w_handshake = tx_valid_q & tx_ready;

    // Next-state, code latch and registered-output decode.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        frame_done_d = 1'b0;
        drop_d       = 1'b0;
        tx_valid_d   = 1'b0;
        tx_data_d    = 8'h00;
        busy_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    // DAQ sets the low nibble and RECORD sets the high
                    // nibble. Both together give 0xFF.
                    code_d  = {{4{req_record}}, {4{req_daq}}};
                    state_d = S_H0;
                end
            end
            S_H0: begin
                if (w_handshake) state_d = S_H1;
            end
            S_H1: begin
                if (w_handshake) state_d = S_CODE;
            end
            S_CODE: begin
                if (w_handshake) state_d = S_CHK;
            end
            S_CHK: begin
                if (w_handshake) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests are not queued. A request that arrives outside IDLE,
        // including one in the final handshake cycle, is discarded and flagged.
        if ((state_q != IDLE) && w_any_req) begin
            drop_d = 1'b1;
        end

        case (state_d)
            S_H0: begin
                tx_valid_d = 1'b1;
                tx_data_d  = HEADER0;
                busy_d     = 1'b1;
            end
            S_H1: begin
                tx_valid_d = 1'b1;
                tx_data_d  = HEADER1;
                busy_d     = 1'b1;
            end
            S_CODE: begin
                tx_valid_d = 1'b1;
                tx_data_d  = code_d;
                busy_d     = 1'b1;
            end
            S_CHK: begin
                tx_valid_d = 1'b1;
                tx_data_d  = HEADER0 ^ HEADER1 ^ code_d;
                busy_d     = 1'b1;
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State, latched code and output registers. An asynchronous reset
    // aborts any frame in progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            code_q       <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
        end
    end

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign drop       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_frame_tx
// Description : Directed self-checking bench for cmd_frame_tx. It uses the
//               default header pair on one instance and AA/55 on a second.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       req_record;
    logic       req_daq;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       drop;

    logic       req_record_b;
    logic       req_daq_b;
    logic       tx_ready_b;
    logic       tx_valid_b;
    logic [7:0] tx_data_b;
    logic       busy_b;
    logic       frame_done_b;
    logic       drop_b;

    int n_vec = 0;
    int n_err = 0;

    // Ready pattern for the stall test. Element 0 applies in the first cycle of the frame.
    logic [0:6] st_pat = 7'b1001011;
    logic [7:0] st_exp [4] = '{8'hEB, 8'h90, 8'hF0, 8'h8B};
    logic [7:0] alt_exp[4] = '{8'hAA, 8'h55, 8'h0F, 8'hF0};

    cmd_frame_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_record (req_record),
        .req_daq    (req_daq),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done),
        .drop       (drop)
    );

    cmd_frame_tx #(
        .HEADER0 (8'hAA),
        .HEADER1 (8'h55)
    ) dut_alt (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_record (req_record_b),
        .req_daq    (req_daq_b),
        .tx_ready   (tx_ready_b),
        .tx_valid   (tx_valid_b),
        .tx_data    (tx_data_b),
        .busy       (busy_b),
        .frame_done (frame_done_b),
        .drop       (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one frame with tx_ready held high and check each byte, the closing pulse and the IDLE that follows.
    task automatic run_frame(input logic rec, input logic daq, input logic [7:0] code,
                             input logic [7:0] chk, input string tag);
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEB;
        exp_b[1] = 8'h90;
        exp_b[2] = code;
        exp_b[3] = chk;
        tx_ready   = 1'b1;
        req_record = rec;
        req_daq    = daq;
        tick();
        req_record = 1'b0;
        req_daq    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_valid%0d", tag, i), {31'd0, tx_valid}, 32'd1);
            check_val($sformatf("%s_data%0d", tag, i), {24'd0, tx_data}, {24'd0, exp_b[i]});
            check_val($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            check_val($sformatf("%s_done%0d", tag, i), {31'd0, frame_done}, 32'd0);
            check_val($sformatf("%s_drop%0d", tag, i), {31'd0, drop}, 32'd0);
            tick();
        end
        check_val($sformatf("%s_done", tag), {31'd0, frame_done}, 32'd1);
        check_val($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd0);
        check_val($sformatf("%s_valid_end", tag), {31'd0, tx_valid}, 32'd0);
        tick();
        check_val($sformatf("%s_done_clr", tag), {31'd0, frame_done}, 32'd0);
        check_val($sformatf("%s_idle", tag), {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        int idx;
        rst_n        = 1'b0;
        req_record   = 1'b0;
        req_daq      = 1'b0;
        tx_ready     = 1'b0;
        req_record_b = 1'b0;
        req_daq_b    = 1'b0;
        tx_ready_b   = 1'b1;

        // Reset values
        tick();
        tick();
        check_val("rst_valid", {31'd0, tx_valid}, 32'd0);
        check_val("rst_data", {24'd0, tx_data}, 32'h00);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_drop", {31'd0, drop}, 32'd0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        check_val("idle_valid", {31'd0, tx_valid}, 32'd0);

        // Basic frames
        run_frame(1'b0, 1'b1, 8'h0F, 8'h74, "daq");
        run_frame(1'b1, 1'b1, 8'hFF, 8'h84, "both");
        run_frame(1'b1, 1'b0, 8'hF0, 8'h8B, "rec");

        // Back-pressure: each byte must hold until its handshake
        req_record = 1'b1;
        tx_ready   = 1'b0;
        tick();
        req_record = 1'b0;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            tx_ready = st_pat[i];
            check_val($sformatf("stall_valid%0d", i), {31'd0, tx_valid}, 32'd1);
            check_val($sformatf("stall_data%0d", i), {24'd0, tx_data}, {24'd0, st_exp[idx]});
            check_val($sformatf("stall_done%0d", i), {31'd0, frame_done}, 32'd0);
            if (st_pat[i]) idx++;
            tick();
        end
        tx_ready = 1'b1;
        check_val("stall_done", {31'd0, frame_done}, 32'd1);
        check_val("stall_valid_end", {31'd0, tx_valid}, 32'd0);
        tick();
        check_val("stall_done_clr", {31'd0, frame_done}, 32'd0);

        // Requests during a frame are dropped
        req_daq = 1'b1;
        tick();                 // S_H0
        req_daq = 1'b0;
        tick();                 // S_H1
        req_record = 1'b1;
        tick();                 // S_CODE
        req_record = 1'b0;
        check_val("drop1_pulse", {31'd0, drop}, 32'd1);
        check_val("drop1_data", {24'd0, tx_data}, 32'h0F);
        tick();                 // S_CHK
        check_val("drop1_clr", {31'd0, drop}, 32'd0);
        check_val("drop_chk_data", {24'd0, tx_data}, 32'h74);
        req_daq = 1'b1;         // arrives in the checksum handshake cycle
        tick();                 // IDLE
        req_daq = 1'b0;
        check_val("drop2_pulse", {31'd0, drop}, 32'd1);
        check_val("drop2_done", {31'd0, frame_done}, 32'd1);
        check_val("drop2_valid", {31'd0, tx_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("drop_nofr_valid%0d", i), {31'd0, tx_valid}, 32'd0);
            check_val($sformatf("drop_nofr_busy%0d", i), {31'd0, busy}, 32'd0);
            check_val($sformatf("drop_nofr_drop%0d", i), {31'd0, drop}, 32'd0);
        end

        // Asynchronous reset in S_CODE with tx_ready low
        req_daq = 1'b1;
        tick();                 // S_H0
        req_daq = 1'b0;
        tick();                 // S_H1
        tick();                 // S_CODE
        tx_ready = 1'b0;
        tick();
        check_val("arst_pre_data", {24'd0, tx_data}, 32'h0F);
        check_val("arst_pre_valid", {31'd0, tx_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, tx_valid}, 32'd0);
        check_val("arst_data", {24'd0, tx_data}, 32'h00);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_done", {31'd0, frame_done}, 32'd0);
        tick();
        check_val("arst_hold_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("arst_idle_valid%0d", i), {31'd0, tx_valid}, 32'd0);
            check_val($sformatf("arst_idle_done%0d", i), {31'd0, frame_done}, 32'd0);
        end
        run_frame(1'b0, 1'b1, 8'h0F, 8'h74, "post_rst");

        // Alternate header parameters
        req_daq_b = 1'b1;
        tick();
        req_daq_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("alt_valid%0d", i), {31'd0, tx_valid_b}, 32'd1);
            check_val($sformatf("alt_data%0d", i), {24'd0, tx_data_b}, {24'd0, alt_exp[i]});
            tick();
        end
        check_val("alt_done", {31'd0, frame_done_b}, 32'd1);
        check_val("alt_busy_end", {31'd0, busy_b}, 32'd0);
        check_val("alt_drop", {31'd0, drop_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
